add_share_ctrl: RTL and testbench
=================================

# add_share_ctrl

Sequencing controller that time-shares one select-add datapath, computing {CO, SUM} = S ? A+B : A+C, among N independent requesters. It arbitrates round-robin, captures the winner's operands, runs the add, and returns the tagged result on a valid/ready response channel. It sits between client blocks and the shared adder so that only one adder instance exists in the design.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- W, 4, operand width
- IDW, $clog2(N), requester ID width

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- REQ_VALID  input  N  per-requester request valid
- REQ_A  input  N*W  operand A, requester i at [i*W +: W]
- REQ_B  input  N*W  operand B, packed as REQ_A
- REQ_C  input  N*W  operand C, packed as REQ_A
- REQ_S  input  N  select: 1 computes A+B, 0 computes A+C
- REQ_READY  output  N  one-hot accept pulse to the granted requester
- RSP_VALID  output  1  result valid
- RSP_READY  input  1  consumer accepts result
- RSP_ID  output  IDW  index of the requester the result belongs to
- RSP_SUM  output  W  sum
- RSP_CO  output  1  carry out

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, no REQ_VALID bits set: stay in IDLE, REQ_READY = 0.
- IDLE, any REQ_VALID bit set:
  - The winner is the first set bit searching upward from (ptr+1) mod N, wrapping.
  - REQ_READY[winner] = 1 combinationally this cycle; that is the transfer.
  - Latch the winner's A, B, C, S and ID. Set ptr = winner. Go to EXEC.
- EXEC: compute the (W+1)-bit sum of zero-extended operands. Register CO (MSB), SUM (low W bits) and ID. Go to RESP.
- RESP: RSP_VALID = 1 with stable RSP_ID, RSP_SUM and RSP_CO.
  - If RSP_READY = 1, go to IDLE. RSP_VALID drops the next cycle.
  - If RSP_READY = 0, hold.
- REQ_READY is 0 in EXEC and RESP. Requests arriving then wait. They are never dropped or reordered per requester.
- Requesters hold REQ_VALID and operands stable until their REQ_READY pulse. Withdrawing a request before the grant is legal: arbitration uses the current cycle only.
- Simultaneous requests: exactly one grant per arbitration. With all N requesting continuously, grants rotate 0,1,…,N-1,0,…
- Arithmetic: unsigned and wrap-free. CO captures the overflow, e.g. F+1 gives SUM=0, CO=1.

## Timing
- Reset (RST_N low, any time):
  - State goes to IDLE and ptr = N-1, so requester 0 has first priority.
  - RSP_VALID = 0, RSP_ID = 0, RSP_SUM = 0, RSP_CO = 0, REQ_READY = 0.
  - An in-flight operation is discarded and no response is issued after release.
- Latency: grant in cycle T, RSP_VALID high from the edge ending T+1, i.e. visible in cycle T+2.
- Minimum issue interval is 3 cycles (IDLE → EXEC → RESP with immediate RSP_READY).
- Response outputs are registered. REQ_READY is combinational from REQ_VALID and ptr, gated by state == IDLE.
- RSP_READY high while RSP_VALID is low has no effect.

## Structure
- A shared package holds the state encoding enum (IDLE=0, EXEC=1, RESP=2) and the default constants N=4 and W=4.
- Sub-module rr_pick(N): combinational round-robin picker with inputs req[N] and ptr, outputs gnt_onehot[N], gnt_idx and any.
  - Reused by later arbiters in the design.
- The adder expression stays inline. It is a single continuous assignment and does not need its own instance.

## Test plan
- Single request: requester 2 with A=3, B=4, C=9, S=1.
  - REQ_READY=0100 in cycle T, then RSP_VALID in cycle T+2 with ID=2, SUM=7, CO=0.
- Select and carry: A=F, B=1, C=8, S=0.
  - Required response: SUM=7, CO=1.
  - Repeat with S=1: SUM=0, CO=1.
- All four requesting continuously with RSP_READY tied high:
  - Grant order 0,1,2,3,0,1, each grant 3 cycles apart.
  - Each RSP_ID matches its grant.
- Backpressure: hold RSP_READY=0 for 5 cycles in RESP.
  - RSP_VALID and data stay stable, no REQ_READY pulse.
  - Next grant occurs the cycle after state returns to IDLE.
- Fairness after a gap: only requester 3 requests and is served; then requesters 0 and 3 request together.
  - Requester 0 wins because ptr=3.
- Reset mid-operation: assert RST_N low during EXEC.
  - All outputs go to 0 immediately and no response appears after release.
  - First grant after reset goes to the lowest-index requester.

Source files
------------

// File: rtl/add_share_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// add_share_ctrl_pkg
//   Shared definitions for the time-shared select-add controller and the
//   round-robin picker.
//   Contents:
//     state_e  - controller state encoding (IDLE=0, EXEC=1, RESP=2)
//     DEF_N    - default number of requesters
//     DEF_W    - default operand width
// ---------------------------------------------------------------------------
package add_share_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int DEF_N = 4;
   localparam int DEF_W = 4;

endpackage

// File: rtl/add_share_ctrl_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. The search starts one position above
//   ptr and wraps, so the last winner has the lowest priority next time.
//   Ports:
//     req        in  [N]    request vector
//     ptr        in  [IDW]  index of the previous winner
//     gnt_onehot out [N]    one-hot grant (all zero when nothing requests)
//     gnt_idx    out [IDW]  index of the granted requester
//     any        out        at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt_onehot,
   output logic [IDW-1:0] gnt_idx,
   output logic           any
);

   logic           found;
   logic [IDW-1:0] k_idx;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      found      = 1'b0;
      k_idx      = '0;
      // Walk ptr+1, ptr+2, ... ptr+N (mod N); the last step revisits ptr
      // itself so a lone request from the previous winner is still served.
      for (int i = 1; i <= N; i++) begin
         k_idx = IDW'((int'(ptr) + i) % N);
         if (!found && req[k_idx]) begin
            found             = 1'b1;
            gnt_onehot[k_idx] = 1'b1;
            gnt_idx           = k_idx;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/add_share_ctrl.sv
// ---------------------------------------------------------------------------
// add_share_ctrl
//   Time-shares one select-add datapath ({CO,SUM} = S ? A+B : A+C) among N
//   requesters. Round-robin grant in IDLE, add in EXEC, hold the tagged
//   result in RESP until the consumer takes it.
//
//   Handshakes: a request transfers in the cycle REQ_VALID[i] and
//   REQ_READY[i] are both high; REQ_READY is a one-cycle, one-hot pulse
//   seen only in IDLE. A response transfers in the cycle RSP_VALID and
//   RSP_READY are both high; while RSP_VALID is high RSP_ID/SUM/CO are
//   stable, and RSP_READY has no effect while RSP_VALID is low.
//
//   Ports:
//     CLK, RST_N        clock (rising edge), async active-low reset
//     REQ_VALID [N]     per-requester request valid
//     REQ_A/B/C [N*W]   operands, requester i at [i*W +: W]
//     REQ_S [N]         1: A+B, 0: A+C
//     REQ_READY [N]     one-hot accept pulse
//     RSP_VALID/READY   response handshake
//     RSP_ID [IDW]      requester the result belongs to
//     RSP_SUM [W]       low W bits of the sum
//     RSP_CO            carry out
//     DBG_STATE         current controller state, for observation only
// ---------------------------------------------------------------------------
module add_share_ctrl
   import add_share_ctrl_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int W   = DEF_W,
   parameter int IDW = $clog2(N)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [N-1:0]     REQ_VALID,
   input  logic [N*W-1:0]   REQ_A,
   input  logic [N*W-1:0]   REQ_B,
   input  logic [N*W-1:0]   REQ_C,
   input  logic [N-1:0]     REQ_S,
   output logic [N-1:0]     REQ_READY,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic [IDW-1:0]   RSP_ID,
   output logic [W-1:0]     RSP_SUM,
   output logic             RSP_CO,
   output state_e           DBG_STATE
);

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;

   // Captured operands of the granted request
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   c_q, c_d;
   logic           s_q, s_d;
   logic [IDW-1:0] id_q, id_d;

   // Registered response
   logic [W-1:0]   sum_q, sum_d;
   logic           co_q, co_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;

   logic [N-1:0]   gnt_onehot;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_any;
   logic           grant;
   logic [W:0]     add_res;

   rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_rr_pick (
      .req        (REQ_VALID),
      .ptr        (ptr_q),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (gnt_any)
   );

   assign grant = (state_q == ST_IDLE) && gnt_any;

   // The one shared adder: zero-extended so the carry lands in the MSB.
   assign add_res = {1'b0, a_q} + (s_q ? {1'b0, b_q} : {1'b0, c_q});

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (gnt_any)   state_d = ST_EXEC;
         ST_EXEC:                state_d = ST_RESP;
         ST_RESP: if (RSP_READY) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      REQ_READY = (state_q == ST_IDLE) ? gnt_onehot : '0;
      RSP_VALID = (state_q == ST_RESP);
      RSP_ID    = rsp_id_q;
      RSP_SUM   = sum_q;
      RSP_CO    = co_q;
      DBG_STATE = state_q;
   end

   // ---------------- Datapath next values ----------------
   always_comb begin
      ptr_d    = ptr_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      s_d      = s_q;
      id_d     = id_q;
      sum_d    = sum_q;
      co_d     = co_q;
      rsp_id_d = rsp_id_q;

      if (grant) begin
         // One-hot mux over requesters; exactly one bit of gnt_onehot is set.
         for (int i = 0; i < N; i++) begin
            if (gnt_onehot[i]) begin
               a_d = REQ_A[i*W +: W];
               b_d = REQ_B[i*W +: W];
               c_d = REQ_C[i*W +: W];
               s_d = REQ_S[i];
            end
         end
         id_d  = gnt_idx;
         ptr_d = gnt_idx;
      end

      if (state_q == ST_EXEC) begin
         sum_d    = add_res[W-1:0];
         co_d     = add_res[W];
         rsp_id_d = id_q;
      end
   end

   // ---------------- Datapath registers ----------------
   // ptr resets to N-1 so requester 0 is first in line after reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr_q    <= IDW'(N - 1);
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         s_q      <= 1'b0;
         id_q     <= '0;
         sum_q    <= '0;
         co_q     <= 1'b0;
         rsp_id_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         s_q      <= s_d;
         id_q     <= id_d;
         sum_q    <= sum_d;
         co_q     <= co_d;
         rsp_id_q <= rsp_id_d;
      end
   end

endmodule

// File: tb/tb_add_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_add_share_ctrl
//   Directed bench for add_share_ctrl (N=4, W=4). Inputs change and outputs
//   are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_add_share_ctrl;
   import add_share_ctrl_pkg::*;

   localparam int N   = 4;
   localparam int W   = 4;
   localparam int IDW = 2;

   logic           CLK = 1'b0;
   logic           RST_N;
   logic [N-1:0]   REQ_VALID;
   logic [N*W-1:0] REQ_A;
   logic [N*W-1:0] REQ_B;
   logic [N*W-1:0] REQ_C;
   logic [N-1:0]   REQ_S;
   logic [N-1:0]   REQ_READY;
   logic           RSP_VALID;
   logic           RSP_READY;
   logic [IDW-1:0] RSP_ID;
   logic [W-1:0]   RSP_SUM;
   logic           RSP_CO;
   state_e         dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [IDW-1:0] exp_q[$];

   add_share_ctrl #(.N(N), .W(W), .IDW(IDW)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .REQ_VALID (REQ_VALID),
      .REQ_A     (REQ_A),
      .REQ_B     (REQ_B),
      .REQ_C     (REQ_C),
      .REQ_S     (REQ_S),
      .REQ_READY (REQ_READY),
      .RSP_VALID (RSP_VALID),
      .RSP_READY (RSP_READY),
      .RSP_ID    (RSP_ID),
      .RSP_SUM   (RSP_SUM),
      .RSP_CO    (RSP_CO),
      .DBG_STATE (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic s);
      REQ_VALID[i]     = 1'b1;
      REQ_A[i*W +: W]  = a;
      REQ_B[i*W +: W]  = b;
      REQ_C[i*W +: W]  = c;
      REQ_S[i]         = s;
   endtask

   task automatic check_rsp(input string tag, input logic [IDW-1:0] id,
                            input logic [W-1:0] sum, input logic co);
      check({tag, "_valid"}, RSP_VALID, 1);
      check({tag, "_id"},    RSP_ID,    id);
      check({tag, "_sum"},   RSP_SUM,   sum);
      check({tag, "_co"},    RSP_CO,    co);
   endtask

   // Lone request from idle with RSP_READY high: grant now, response at T+2.
   task automatic do_single(input string tag, input int i, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] c, input logic s,
                            input logic [W-1:0] sum, input logic co);
      set_req(i, a, b, c, s);
      #1;
      check({tag, "_gnt"}, REQ_READY, 32'd1 << i);
      tick();
      REQ_VALID[i] = 1'b0;
      #1;
      check({tag, "_exec_rdy"},   REQ_READY, 0);
      check({tag, "_exec_valid"}, RSP_VALID, 0);
      tick();
      check_rsp(tag, IDW'(i), sum, co);
      tick();
      check({tag, "_after_valid"}, RSP_VALID, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [IDW-1:0] id;
      RST_N     = 1'b0;
      REQ_VALID = '0;
      REQ_A     = '0;
      REQ_B     = '0;
      REQ_C     = '0;
      REQ_S     = '0;
      RSP_READY = 1'b1;
      #1;
      check("rst_valid", RSP_VALID, 0);
      check("rst_id",    RSP_ID,    0);
      check("rst_sum",   RSP_SUM,   0);
      check("rst_co",    RSP_CO,    0);
      check("rst_ready", REQ_READY, 0);
      check("rst_state", dbg_state, ST_IDLE);
      tick();
      tick();
      RST_N = 1'b1;
      tick();

      // Single request, then select/carry cases (requester 3 leaves ptr=3)
      do_single("single", 2, 4'h3, 4'h4, 4'h9, 1'b1, 4'h7, 1'b0);
      do_single("carry_c", 3, 4'hF, 4'h1, 4'h8, 1'b0, 4'h7, 1'b1);
      do_single("carry_b", 3, 4'hF, 4'h1, 4'h8, 1'b1, 4'h0, 1'b1);

      // All four requesting continuously: A=i, B=i+1, S=1 -> SUM=2i+1
      for (int i = 0; i < N; i++) set_req(i, W'(i), W'(i + 1), 4'hF, 1'b1);
      #1;
      for (int g = 0; g < 6; g++) begin
         check($sformatf("rot_gnt%0d", g), REQ_READY, 32'd1 << (g % N));
         exp_q.push_back(IDW'(g % N));
         tick();
         if (g == 5) REQ_VALID = '0;
         #1;
         check($sformatf("rot_exec_rdy%0d", g), REQ_READY, 0);
         tick();
         id = exp_q.pop_front();
         check_rsp($sformatf("rot_rsp%0d", g), id, W'(2 * int'(id) + 1), 1'b0);
         tick();
      end
      check("rot_idle_rdy", REQ_READY, 0);
      check("rot_q_empty", exp_q.size(), 0);

      // Backpressure: ptr=1, requester 0 alone wins; 9+9=18 -> SUM=2, CO=1
      RSP_READY = 1'b0;
      set_req(0, 4'h9, 4'h9, 4'h0, 1'b1);
      #1;
      check("bp_gnt0", REQ_READY, 4'b0001);
      tick();
      REQ_VALID[0] = 1'b0;
      set_req(1, 4'h5, 4'h6, 4'h2, 1'b0);
      #1;
      check("bp_exec_rdy", REQ_READY, 0);
      tick();
      for (int k = 0; k < 5; k++) begin
         check_rsp($sformatf("bp_hold%0d", k), 2'd0, 4'h2, 1'b1);
         check($sformatf("bp_hold_rdy%0d", k), REQ_READY, 0);
         tick();
      end
      RSP_READY = 1'b1;
      #1;
      check_rsp("bp_release", 2'd0, 4'h2, 1'b1);
      check("bp_release_rdy", REQ_READY, 0);
      tick();
      check("bp_next_gnt", REQ_READY, 4'b0010);
      tick();
      REQ_VALID[1] = 1'b0;
      tick();
      check_rsp("bp_rsp1", 2'd1, 4'h7, 1'b0);
      tick();
      check("bp_after_valid", RSP_VALID, 0);

      // Fairness after a gap: serve 3 alone, then 0 and 3 together -> 0 wins
      do_single("fair3", 3, 4'h2, 4'h3, 4'h4, 1'b0, 4'h6, 1'b0);
      set_req(0, 4'h1, 4'h1, 4'h0, 1'b1);
      set_req(3, 4'h2, 4'h3, 4'h4, 1'b0);
      #1;
      check("fair_gnt0", REQ_READY, 4'b0001);
      tick();
      REQ_VALID[0] = 1'b0;
      tick();
      check_rsp("fair_rsp0", 2'd0, 4'h2, 1'b0);
      tick();
      check("fair_gnt3", REQ_READY, 4'b1000);
      tick();
      REQ_VALID[3] = 1'b0;
      tick();
      check_rsp("fair_rsp3", 2'd3, 4'h6, 1'b0);
      tick();

      // Reset during EXEC: ptr would be 1 without reset
      set_req(1, 4'h4, 4'h4, 4'h4, 1'b1);
      #1;
      check("rmid_gnt", REQ_READY, 4'b0010);
      tick();
      REQ_VALID[1] = 1'b0;
      #1;
      check("rmid_exec", dbg_state, ST_EXEC);
      #2;
      RST_N = 1'b0;
      #1;
      check("rmid_valid", RSP_VALID, 0);
      check("rmid_id",    RSP_ID,    0);
      check("rmid_sum",   RSP_SUM,   0);
      check("rmid_co",    RSP_CO,    0);
      check("rmid_state", dbg_state, ST_IDLE);
      tick();
      tick();
      RST_N = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("rmid_no_rsp%0d", k), RSP_VALID, 0);
      end
      set_req(0, 4'h7, 4'h8, 4'h0, 1'b1);
      set_req(2, 4'h1, 4'h1, 4'h1, 1'b1);
      #1;
      check("rmid_first_gnt", REQ_READY, 4'b0001);
      tick();
      REQ_VALID = '0;
      tick();
      check_rsp("rmid_rsp0", 2'd0, 4'hF, 1'b0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
